// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the multi-sprite bouncer.
//   sweepState_e : sweep FSM encoding (IDLE, SWEEP, DONE)
//   CLAMP_W      : working width of the clamp helper (wide enough for any
//                  supported coordinate width)
//   idxWidth()   : sprite index width, $clog2(n) but never narrower than 1 bit
//   clampCoord() : saturates a coordinate into [lo, hi]
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweepState_e;

    localparam int CLAMP_W = 16;

    // A single sprite still needs a 1-bit index so the index mux stays legal.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Loads from the game controller may point anywhere on (or off) the
    // screen, so centres are pulled back into the legal range.
    function automatic logic [CLAMP_W-1:0] clampCoord(
        input logic [CLAMP_W-1:0] v,
        input logic [CLAMP_W-1:0] lo,
        input logic [CLAMP_W-1:0] hi
    );
        logic [CLAMP_W-1:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_bouncer_axis.sv
// -----------------------------------------------------------------------------
// bounce_axis
// Combinational single-axis stepper shared by all sprites.
//   pos_i      : current centre coordinate
//   dir_i      : 1 = moving towards larger coordinates
//   min_i/max_i: legal centre range
//   step_i     : pixels per tick
//   nextPos_o  : updated centre
//   nextDir_o  : updated direction
//   hit_o      : high when this step reflected off a limit
// -----------------------------------------------------------------------------
module bounce_axis #(
    parameter int W = 10
) (
    input  logic [W-1:0] pos_i,
    input  logic         dir_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    input  logic [2:0]   step_i,
    output logic [W-1:0] nextPos_o,
    output logic         nextDir_o,
    output logic         hit_o
);

    logic [W:0] sumUp;
    logic [W:0] lowLimit;

    // Compare one bit wider than the coordinate so neither the forward sum
    // nor the reflection threshold can wrap. Moving up, overshooting the
    // maximum pins the sprite on it and reverses; moving down, anything that
    // would land under the minimum pins it on the minimum and reverses.
    always_comb begin
        sumUp     = {1'b0, pos_i} + (W+1)'(step_i);
        lowLimit  = {1'b0, min_i} + (W+1)'(step_i);
        nextPos_o = pos_i;
        nextDir_o = dir_i;
        hit_o     = 1'b0;
        if (dir_i) begin
            if (sumUp > {1'b0, max_i}) begin
                nextPos_o = max_i;
                nextDir_o = 1'b0;
                hit_o     = 1'b1;
            end else begin
                nextPos_o = sumUp[W-1:0];
            end
        end else begin
            if ({1'b0, pos_i} < lowLimit) begin
                nextPos_o = min_i;
                nextDir_o = 1'b1;
                hit_o     = 1'b1;
            end else begin
                nextPos_o = pos_i - W'(step_i);
            end
        end
    end

endmodule

// File: rtl/sprite_bouncer.sv
// -----------------------------------------------------------------------------
// sprite_bouncer
// Keeps centre and direction for N_OBJ sprites and moves them once per
// animation tick, one sprite per cycle, through a shared X/Y stepper pair.
//   clk, rst           : clock, synchronous active-low reset
//   pixclk, animate    : tick = pixclk && animate
//   ld_valid/ld_ready  : runtime position/direction load (accepted in IDLE)
//   ld_idx, ld_x, ld_y : target sprite and new centre (clamped)
//   ld_dx, ld_dy       : new directions
//   o_xl/o_xr/o_yt/o_yb: packed registered sprite bounds
//   bounce             : per-sprite reflection pulse
//   busy, frame_done   : sweep in progress / end-of-sweep pulse
//   tick_missed        : tick arrived while a sweep was running
// -----------------------------------------------------------------------------
module sprite_bouncer
    import sprite_pkg::*;
#(
    parameter int                         N_OBJ    = 2,
    parameter int                         COORD_W  = 10,
    parameter logic [COORD_W-1:0]         HALF_W   = 10'd80,
    parameter logic [COORD_W-1:0]         HALF_H   = 10'd80,
    parameter logic [2:0]                 STEP     = 3'd1,
    parameter int                         D_WIDTH  = 640,
    parameter int                         D_HEIGHT = 480,
    parameter logic [N_OBJ*COORD_W-1:0]   INIT_X   = {N_OBJ{10'd320}},
    parameter logic [N_OBJ*COORD_W-1:0]   INIT_Y   = {N_OBJ{10'd240}},
    parameter logic [N_OBJ-1:0]           INIT_DX  = '1,
    parameter logic [N_OBJ-1:0]           INIT_DY  = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pixclk,
    input  logic                       animate,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [3:0]                 ld_idx,
    input  logic [COORD_W-1:0]         ld_x,
    input  logic [COORD_W-1:0]         ld_y,
    input  logic                       ld_dx,
    input  logic                       ld_dy,
    output logic [N_OBJ*COORD_W-1:0]   o_xl,
    output logic [N_OBJ*COORD_W-1:0]   o_xr,
    output logic [N_OBJ*COORD_W-1:0]   o_yt,
    output logic [N_OBJ*COORD_W-1:0]   o_yb,
    output logic [N_OBJ-1:0]           bounce,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       tick_missed
);

    localparam int                 IDX_W = idxWidth(N_OBJ);
    localparam logic [COORD_W-1:0] XMIN  = HALF_W;
    localparam logic [COORD_W-1:0] XMAX  = COORD_W'(D_WIDTH - 1) - HALF_W;
    localparam logic [COORD_W-1:0] YMIN  = HALF_H;
    localparam logic [COORD_W-1:0] YMAX  = COORD_W'(D_HEIGHT - 1) - HALF_H;

    sweepState_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [COORD_W-1:0]   posX_q [N_OBJ];
    logic [COORD_W-1:0]   posY_q [N_OBJ];
    logic [N_OBJ-1:0]     dirX_q;
    logic [N_OBJ-1:0]     dirY_q;

    logic [N_OBJ*COORD_W-1:0] xl_q, xr_q, yt_q, yb_q;
    logic [N_OBJ-1:0]     bounce_q;
    logic                 tickMissed_q;

    logic                 tick;
    logic                 loadFire;
    logic                 sweepWrite;
    logic [COORD_W-1:0]   ldXClamped, ldYClamped;
    logic [COORD_W-1:0]   curX, curY, nextX, nextY;
    logic                 nextDirX, nextDirY, hitX, hitY;

    assign tick       = pixclk && animate;
    assign ld_ready   = (state_q == IDLE);
    assign loadFire   = ld_valid && ld_ready;
    assign sweepWrite = (state_q == SWEEP);

    assign ldXClamped = COORD_W'(clampCoord(CLAMP_W'(ld_x), CLAMP_W'(XMIN), CLAMP_W'(XMAX)));
    assign ldYClamped = COORD_W'(clampCoord(CLAMP_W'(ld_y), CLAMP_W'(YMIN), CLAMP_W'(YMAX)));

    assign curX = posX_q[idx_q];
    assign curY = posY_q[idx_q];

    bounce_axis #(.W(COORD_W)) uStepX (
        .pos_i     (curX),
        .dir_i     (dirX_q[idx_q]),
        .min_i     (XMIN),
        .max_i     (XMAX),
        .step_i    (STEP),
        .nextPos_o (nextX),
        .nextDir_o (nextDirX),
        .hit_o     (hitX)
    );

    bounce_axis #(.W(COORD_W)) uStepY (
        .pos_i     (curY),
        .dir_i     (dirY_q[idx_q]),
        .min_i     (YMIN),
        .max_i     (YMAX),
        .step_i    (STEP),
        .nextPos_o (nextY),
        .nextDir_o (nextDirY),
        .hit_o     (hitY)
    );

    // Sweep state register. Reset wins over everything, including a sweep
    // that is half way through the sprite list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Sweep sequencing: a tick in IDLE starts at sprite 0, each SWEEP cycle
    // handles one sprite, and a single DONE cycle closes the frame. Ticks
    // seen outside IDLE are simply not acted on here.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (idx_q == IDX_W'(N_OBJ - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sprite state. Loads only happen in IDLE and stepper writes only in
    // SWEEP, so the two never compete for the same sprite. A load that
    // shares its IDLE cycle with a tick lands first, so the sweep that
    // follows already sees the new centre. Indices past N_OBJ match no
    // sprite and are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_OBJ; i++) begin
                posX_q[i] <= INIT_X[i*COORD_W +: COORD_W];
                posY_q[i] <= INIT_Y[i*COORD_W +: COORD_W];
                dirX_q[i] <= INIT_DX[i];
                dirY_q[i] <= INIT_DY[i];
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (loadFire && (ld_idx == 4'(i))) begin
                    posX_q[i] <= ldXClamped;
                    posY_q[i] <= ldYClamped;
                    dirX_q[i] <= ld_dx;
                    dirY_q[i] <= ld_dy;
                end else if (sweepWrite && (idx_q == IDX_W'(i))) begin
                    posX_q[i] <= nextX;
                    posY_q[i] <= nextY;
                    dirX_q[i] <= nextDirX;
                    dirY_q[i] <= nextDirY;
                end
            end
        end
    end

    // Output registers. Bounds trail the sprite state by one edge so the
    // compositor only ever sees flop outputs. The bounce and missed-tick
    // pulses are rebuilt every cycle so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_OBJ; i++) begin
                xl_q[i*COORD_W +: COORD_W] <= INIT_X[i*COORD_W +: COORD_W] - HALF_W;
                xr_q[i*COORD_W +: COORD_W] <= INIT_X[i*COORD_W +: COORD_W] + HALF_W;
                yt_q[i*COORD_W +: COORD_W] <= INIT_Y[i*COORD_W +: COORD_W] - HALF_H;
                yb_q[i*COORD_W +: COORD_W] <= INIT_Y[i*COORD_W +: COORD_W] + HALF_H;
            end
            bounce_q     <= '0;
            tickMissed_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                xl_q[i*COORD_W +: COORD_W] <= posX_q[i] - HALF_W;
                xr_q[i*COORD_W +: COORD_W] <= posX_q[i] + HALF_W;
                yt_q[i*COORD_W +: COORD_W] <= posY_q[i] - HALF_H;
                yb_q[i*COORD_W +: COORD_W] <= posY_q[i] + HALF_H;
                bounce_q[i] <= sweepWrite && (idx_q == IDX_W'(i)) && (hitX || hitY);
            end
            tickMissed_q <= tick && (state_q != IDLE);
        end
    end

    assign o_xl        = xl_q;
    assign o_xr        = xr_q;
    assign o_yt        = yt_q;
    assign o_yb        = yb_q;
    assign bounce      = bounce_q;
    assign tick_missed = tickMissed_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);

endmodule

// File: tb/tb_sprite_bouncer.sv
// -----------------------------------------------------------------------------
// tb_sprite_bouncer
// Directed bench for sprite_bouncer: one instance with default parameters and
// one with STEP=3 share the same stimulus; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sprite_bouncer;

    logic        clk;
    logic        rst;
    logic        pixclk;
    logic        animate;
    logic        ld_valid;
    logic [3:0]  ld_idx;
    logic [9:0]  ld_x;
    logic [9:0]  ld_y;
    logic        ld_dx;
    logic        ld_dy;

    logic        ld_ready;
    logic [19:0] o_xl, o_xr, o_yt, o_yb;
    logic [1:0]  bounce;
    logic        busy, frame_done, tick_missed;

    logic        ld_ready3;
    logic [19:0] o_xl3, o_xr3, o_yt3, o_yb3;
    logic [1:0]  bounce3;
    logic        busy3, frame_done3, tick_missed3;

    int errorCount;
    int checkCount;

    logic [1:0]  bounceAtT1, bounceAtT2, bounce3AtT1;
    logic        busyAtT0, doneAtT2;

    sprite_bouncer dut (
        .clk         (clk),
        .rst         (rst),
        .pixclk      (pixclk),
        .animate     (animate),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_idx      (ld_idx),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .ld_dx       (ld_dx),
        .ld_dy       (ld_dy),
        .o_xl        (o_xl),
        .o_xr        (o_xr),
        .o_yt        (o_yt),
        .o_yb        (o_yb),
        .bounce      (bounce),
        .busy        (busy),
        .frame_done  (frame_done),
        .tick_missed (tick_missed)
    );

    sprite_bouncer #(.STEP(3'd3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .pixclk      (pixclk),
        .animate     (animate),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready3),
        .ld_idx      (ld_idx),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .ld_dx       (ld_dx),
        .ld_dy       (ld_dy),
        .o_xl        (o_xl3),
        .o_xr        (o_xr3),
        .o_yt        (o_yt3),
        .o_yb        (o_yb3),
        .bounce      (bounce3),
        .busy        (busy3),
        .frame_done  (frame_done3),
        .tick_missed (tick_missed3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sl(input logic [19:0] v, input int k);
        return 32'(v[k*10 +: 10]);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive all controller-facing inputs in one go.
    task automatic applyStimulus(input logic pix, input logic anim, input logic ldv,
                                 input logic [3:0] idx, input logic [9:0] x, input logic [9:0] y,
                                 input logic dx, input logic dy);
        pixclk   = pix;
        animate  = anim;
        ld_valid = ldv;
        ld_idx   = idx;
        ld_x     = x;
        ld_y     = y;
        ld_dx    = dx;
        ld_dy    = dy;
    endtask

    // One-cycle load, then wait one more edge so the bounds show it.
    task automatic loadSprite(input logic [3:0] idx, input logic [9:0] x, input logic [9:0] y,
                              input logic dx, input logic dy);
        applyStimulus(1'b0, 1'b0, 1'b1, idx, x, y, dx, dy);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
    endtask

    // One tick and the full sweep, returning just after edge t+3.
    task automatic runFrame();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        busyAtT0 = busy;
        nextCycle();
        bounceAtT1  = bounce;
        bounce3AtT1 = bounce3;
        nextCycle();
        bounceAtT2 = bounce;
        doneAtT2   = frame_done;
        nextCycle();
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_xl0", sl(o_xl, 0), 240);
        checkOutput("rst_xr0", sl(o_xr, 0), 400);
        checkOutput("rst_yt0", sl(o_yt, 0), 160);
        checkOutput("rst_yb0", sl(o_yb, 0), 320);
        checkOutput("rst_xl1", sl(o_xl, 1), 240);
        checkOutput("rst_ready", 32'(ld_ready), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_bounce", 32'(bounce), 0);
        checkOutput("rst_done", 32'(frame_done), 0);
        checkOutput("rst_missed", 32'(tick_missed), 0);
        rst = 1'b1;
        nextCycle();

        // animate without pixclk is not a tick
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        checkOutput("notick_busy", 32'(busy), 0);

        // Single tick, timing walked cycle by cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        checkOutput("t0_busy", 32'(busy), 1);
        checkOutput("t0_ready", 32'(ld_ready), 0);
        checkOutput("t0_xl0", sl(o_xl, 0), 240);
        nextCycle();
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_done", 32'(frame_done), 0);
        checkOutput("t1_xl0", sl(o_xl, 0), 240);
        nextCycle();
        checkOutput("t2_busy", 32'(busy), 1);
        checkOutput("t2_done", 32'(frame_done), 1);
        checkOutput("t2_xl0", sl(o_xl, 0), 241);
        checkOutput("t2_yt0", sl(o_yt, 0), 161);
        checkOutput("t2_xl1", sl(o_xl, 1), 240);
        nextCycle();
        checkOutput("t3_busy", 32'(busy), 0);
        checkOutput("t3_done", 32'(frame_done), 0);
        checkOutput("t3_xl1", sl(o_xl, 1), 241);
        checkOutput("t3_yb1", sl(o_yb, 1), 321);

        // Approach the right edge: 558 -> 559 -> reflect at 559 -> 558
        loadSprite(4'd0, 10'd558, 10'd240, 1'b1, 1'b1);
        checkOutput("ld_xr0", sl(o_xr, 0), 638);
        checkOutput("ld_yt0", sl(o_yt, 0), 160);
        runFrame();
        checkOutput("fB_busy0", 32'(busyAtT0), 1);
        checkOutput("fB_xr0", sl(o_xr, 0), 639);
        checkOutput("fB_bounce", 32'(bounceAtT1 | bounceAtT2), 0);
        runFrame();
        checkOutput("fC_xr0", sl(o_xr, 0), 639);
        checkOutput("fC_bounceT1", 32'(bounceAtT1), 1);
        checkOutput("fC_bounceT2", 32'(bounceAtT2), 0);
        checkOutput("fC_done", 32'(doneAtT2), 1);
        runFrame();
        checkOutput("fD_xr0", sl(o_xr, 0), 638);
        checkOutput("fD_yt0", sl(o_yt, 0), 163);
        checkOutput("fD_xl1", sl(o_xl, 1), 244);

        // Clamp on load, and out-of-range index ignored
        loadSprite(4'd1, 10'd700, 10'd5, 1'b1, 1'b0);
        checkOutput("clamp_xr1", sl(o_xr, 1), 639);
        checkOutput("clamp_yt1", sl(o_yt, 1), 0);
        checkOutput("clamp_yb1", sl(o_yb, 1), 160);
        loadSprite(4'd5, 10'd100, 10'd100, 1'b0, 1'b0);
        checkOutput("badidx_xr0", sl(o_xr, 0), 638);
        checkOutput("badidx_xr1", sl(o_xr, 1), 639);

        // Tick held into SWEEP and a load attempted while busy
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sw_ready", 32'(ld_ready), 0);
        checkOutput("sw_missed0", 32'(tick_missed), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 10'd300, 10'd300, 1'b1, 1'b1);
        nextCycle();
        checkOutput("sw_missed1", 32'(tick_missed), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 10'd300, 10'd300, 1'b1, 1'b1);
        nextCycle();
        checkOutput("sw_missed2", 32'(tick_missed), 0);
        checkOutput("sw_done", 32'(frame_done), 1);
        checkOutput("sw_bounce1", 32'(bounce), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sw_busy_end", 32'(busy), 0);
        checkOutput("sw_xr0", sl(o_xr, 0), 637);
        checkOutput("sw_xr1", sl(o_xr, 1), 639);
        checkOutput("sw_yt1", sl(o_yt, 1), 0);
        nextCycle();
        checkOutput("sw_noghost", 32'(busy), 0);

        // STEP=3 instance: low-edge reflection 82 -> 80 -> 83
        rst = 1'b0;
        nextCycle();
        rst = 1'b1;
        loadSprite(4'd0, 10'd82, 10'd240, 1'b0, 1'b1);
        checkOutput("s3_ld_xl0", sl(o_xl3, 0), 2);
        runFrame();
        checkOutput("s3_fF_xl0", sl(o_xl3, 0), 0);
        checkOutput("s3_fF_yt0", sl(o_yt3, 0), 163);
        checkOutput("s3_fF_bounce", 32'(bounce3AtT1), 1);
        checkOutput("s1_fF_xl0", sl(o_xl, 0), 1);
        checkOutput("s1_fF_bounce", 32'(bounceAtT1), 0);
        runFrame();
        checkOutput("s3_fG_xl0", sl(o_xl3, 0), 3);
        checkOutput("s3_fG_yt0", sl(o_yt3, 0), 166);
        checkOutput("s3_fG_xl1", sl(o_xl3, 1), 246);
        checkOutput("s1_fG_xl0", sl(o_xl, 0), 0);

        // Reset in the middle of a sweep
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("mid_busy", 32'(busy), 0);
        checkOutput("mid_done", 32'(frame_done), 0);
        checkOutput("mid_xl0", sl(o_xl, 0), 240);
        checkOutput("mid_xl1", sl(o_xl, 1), 240);
        checkOutput("mid_yt0", sl(o_yt, 0), 160);
        checkOutput("mid_xl0_s3", sl(o_xl3, 0), 240);
        rst = 1'b1;
        nextCycle();
        checkOutput("mid_done_after", 32'(frame_done), 0);
        checkOutput("mid_busy_after", 32'(busy), 0);
        checkOutput("mid_xl0_after", sl(o_xl, 0), 240);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
